// File: rtl/usb_glue_pkg.sv
// Shared types, CRC16 constants and the byte-serial CRC step for the USB receive glue.
package usb_glue_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        HOLD    = 2'd2
    } asm_state_t;

    localparam logic [15:0] CRC16_INIT      = 16'hFFFF;
    localparam logic [15:0] CRC16_POLY_REFL = 16'hA001;
    localparam logic [15:0] CRC16_RESIDUE   = 16'hB001;

    // One byte of the reflected CRC16, data consumed LSB first.
    function automatic logic [15:0] crc16_byte(input logic [15:0] crc, input logic [7:0] data);
        logic [15:0] c;
        c = crc ^ {8'h00, data};
        for (int i = 0; i < 8; i++) begin
            c = c[0] ? ((c >> 1) ^ CRC16_POLY_REFL) : (c >> 1);
        end
        return c;
    endfunction

endpackage

// File: rtl/usb_crc16.sv
// Byte-serial reflected USB CRC16; init together with en seeds 0xFFFF and folds in the byte.
module usb_crc16
    import usb_glue_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        init,
    input  logic        en,
    input  logic [7:0]  data,
    output logic [15:0] crc
);

    logic [15:0] r_crc;

    // CRC register update
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_crc <= CRC16_INIT;
        end else if (en) begin
            r_crc <= crc16_byte(init ? CRC16_INIT : r_crc, data);
        end else if (init) begin
            r_crc <= CRC16_INIT;
        end else begin
            r_crc <= r_crc;
        end
    end

    assign crc = r_crc;

endmodule

// File: rtl/usb_packet_assembler.sv
// Collects strobed bytes into one wide packet, checks the trailing USB CRC16 and
// presents the packet with a valid/ready handshake plus timeout/overrun pulses.
module usb_packet_assembler
    import usb_glue_pkg::*;
#(
    parameter  int PAYLOAD_BYTES = 64,
    parameter  int CRC_BYTES     = 2,
    parameter  int TIMEOUT_CYC   = 255,
    localparam int PKT_BYTES     = PAYLOAD_BYTES + CRC_BYTES,
    localparam int CNT_W         = $clog2(PKT_BYTES + 1)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [7:0]             byte_in,
    input  logic                   new_byte,
    input  logic                   pkt_ready,
    output logic [PKT_BYTES*8-1:0] pkt_out,
    output logic                   pkt_valid,
    output logic                   crc_err,
    output logic                   timeout_err,
    output logic                   overrun,
    output logic [CNT_W-1:0]       byte_count
);

    localparam int               IDLE_W     = $clog2(TIMEOUT_CYC + 1);
    localparam logic [CNT_W-1:0] LAST_CNT   = CNT_W'(PKT_BYTES);
    localparam logic [IDLE_W-1:0] IDLE_LIMIT = IDLE_W'(TIMEOUT_CYC);

    asm_state_t               r_state;
    asm_state_t               w_next_state;
    logic [PKT_BYTES*8-1:0]   r_pkt;
    logic [PKT_BYTES*8-1:0]   w_pkt_shifted;
    logic [CNT_W-1:0]         r_count;
    logic [IDLE_W-1:0]        r_idle;
    logic                     r_pkt_valid;
    logic                     r_timeout;
    logic                     r_overrun;
    logic                     w_take_first;
    logic                     w_take_next;
    logic                     w_hold_done;
    logic                     w_timeout;
    logic                     w_overrun;
    logic                     w_crc_bad;
    logic                     w_last_byte;
    logic                     w_idle_expired;

    assign w_last_byte    = (r_count + CNT_W'(1)) == LAST_CNT;
    assign w_idle_expired = (r_idle + IDLE_W'(1)) == IDLE_LIMIT;

    // FSM state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // FSM next-state logic
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE: begin
                if (new_byte) begin
                    w_next_state = (PKT_BYTES == 1) ? HOLD : COLLECT;
                end else begin
                    w_next_state = IDLE;
                end
            end
            COLLECT: begin
                if (new_byte) begin
                    w_next_state = w_last_byte ? HOLD : COLLECT;
                end else if (w_idle_expired) begin
                    w_next_state = IDLE;
                end else begin
                    w_next_state = COLLECT;
                end
            end
            HOLD: begin
                if (pkt_ready && new_byte) begin
                    w_next_state = (PKT_BYTES == 1) ? HOLD : COLLECT;
                end else if (pkt_ready) begin
                    w_next_state = IDLE;
                end else begin
                    w_next_state = HOLD;
                end
            end
            default: w_next_state = IDLE;
        endcase
    end

    // FSM output decode: which datapath action this cycle performs
    always_comb begin
        w_take_first = 1'b0;
        w_take_next  = 1'b0;
        w_hold_done  = 1'b0;
        w_timeout    = 1'b0;
        w_overrun    = 1'b0;
        case (r_state)
            IDLE: begin
                w_take_first = new_byte;
            end
            COLLECT: begin
                w_take_next = new_byte;
                w_timeout   = !new_byte && w_idle_expired;
            end
            HOLD: begin
                w_take_first = new_byte && pkt_ready;
                w_hold_done  = pkt_ready && !new_byte;
                w_overrun    = new_byte && !pkt_ready;
            end
            default: begin
                w_take_first = 1'b0;
            end
        endcase
    end

    generate
        if (PKT_BYTES == 1) begin : g_single
            assign w_pkt_shifted = byte_in;
        end else begin : g_multi
            assign w_pkt_shifted = {r_pkt[PKT_BYTES*8-9:0], byte_in};
        end
    endgenerate

    // Packet shift register, counters and registered status pulses
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pkt       <= '0;
            r_count     <= '0;
            r_idle      <= '0;
            r_pkt_valid <= 1'b0;
            r_timeout   <= 1'b0;
            r_overrun   <= 1'b0;
        end else begin
            r_pkt_valid <= (w_next_state == HOLD);
            r_timeout   <= w_timeout;
            r_overrun   <= w_overrun;

            if (w_take_first || w_take_next) begin
                r_pkt <= w_pkt_shifted;
            end else begin
                r_pkt <= r_pkt;
            end

            if (w_take_first) begin
                r_count <= CNT_W'(1);
            end else if (w_take_next) begin
                r_count <= r_count + CNT_W'(1);
            end else if (w_timeout || w_hold_done) begin
                r_count <= '0;
            end else begin
                r_count <= r_count;
            end

            // Idle gap only counts while a packet is partially collected
            if ((r_state == COLLECT) && !new_byte && !w_timeout) begin
                r_idle <= r_idle + IDLE_W'(1);
            end else begin
                r_idle <= '0;
            end
        end
    end

    generate
        if (CRC_BYTES == 2) begin : g_crc
            logic [15:0] w_crc;
            usb_crc16 u_crc (
                .clk  (clk),
                .rst  (rst),
                .init (w_take_first),
                .en   (w_take_first || w_take_next),
                .data (byte_in),
                .crc  (w_crc)
            );
            // The CRC register is untouched in HOLD, so the flag stays frozen
            assign w_crc_bad = (w_crc != CRC16_RESIDUE);
        end else begin : g_no_crc
            assign w_crc_bad = 1'b0;
        end
    endgenerate

    assign pkt_out     = r_pkt;
    assign pkt_valid   = r_pkt_valid;
    assign crc_err     = r_pkt_valid & w_crc_bad;
    assign timeout_err = r_timeout;
    assign overrun     = r_overrun;
    assign byte_count  = r_count;

endmodule

// File: tb/tb_usb_packet_assembler.sv
// Directed bench for usb_packet_assembler: default 64+2 build plus 4+0 and 1+0 builds.
module tb_usb_packet_assembler;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic [7:0]   byte_in;
    logic         new_byte, pkt_ready;
    logic [527:0] pkt_out;
    logic         pkt_valid, crc_err, timeout_err, overrun;
    logic [6:0]   byte_count;

    logic [7:0]  d4_byte;
    logic        d4_new, d4_ready;
    logic [31:0] d4_pkt;
    logic        d4_valid, d4_crc, d4_to, d4_ovr;
    logic [2:0]  d4_cnt;

    logic [7:0]  d1_byte;
    logic        d1_new, d1_ready;
    logic [7:0]  d1_pkt;
    logic        d1_valid, d1_crc, d1_to, d1_ovr;
    logic [0:0]  d1_cnt;

    usb_packet_assembler dut (
        .clk(clk), .rst(rst), .byte_in(byte_in), .new_byte(new_byte), .pkt_ready(pkt_ready),
        .pkt_out(pkt_out), .pkt_valid(pkt_valid), .crc_err(crc_err), .timeout_err(timeout_err),
        .overrun(overrun), .byte_count(byte_count)
    );

    usb_packet_assembler #(.PAYLOAD_BYTES(4), .CRC_BYTES(0)) dut4 (
        .clk(clk), .rst(rst), .byte_in(d4_byte), .new_byte(d4_new), .pkt_ready(d4_ready),
        .pkt_out(d4_pkt), .pkt_valid(d4_valid), .crc_err(d4_crc), .timeout_err(d4_to),
        .overrun(d4_ovr), .byte_count(d4_cnt)
    );

    usb_packet_assembler #(.PAYLOAD_BYTES(1), .CRC_BYTES(0)) dut1 (
        .clk(clk), .rst(rst), .byte_in(d1_byte), .new_byte(d1_new), .pkt_ready(d1_ready),
        .pkt_out(d1_pkt), .pkt_valid(d1_valid), .crc_err(d1_crc), .timeout_err(d1_to),
        .overrun(d1_ovr), .byte_count(d1_cnt)
    );

    int n_vec = 0;
    int n_err = 0;
    logic [7:0]   pkt_bytes [66];
    logic [527:0] exp_pkt;

    // Bit-at-a-time reference CRC16 (reflected 0xA001, init 0xFFFF) over the payload
    task automatic build_packet(input logic corrupt);
        logic [15:0] c;
        logic        fb;
        c = 16'hFFFF;
        for (int i = 0; i < 64; i++) begin
            pkt_bytes[i] = 8'(i);
            for (int b = 0; b < 8; b++) begin
                fb = c[0] ^ pkt_bytes[i][b];
                c  = c >> 1;
                if (fb) c = c ^ 16'hA001;
            end
        end
        pkt_bytes[64] = ~c[7:0];
        pkt_bytes[65] = ~c[15:8];
        if (corrupt) pkt_bytes[10] = pkt_bytes[10] ^ 8'h01;
        for (int i = 0; i < 66; i++) exp_pkt[(65-i)*8 +: 8] = pkt_bytes[i];
    endtask

    task automatic send_range(input int first, input int last);
        for (int i = first; i <= last; i++) begin
            byte_in  = pkt_bytes[i];
            new_byte = 1'b1;
            @(posedge clk); #1;
        end
        new_byte = 1'b0;
    endtask

    task automatic accept_packet();
        pkt_ready = 1'b1;
        @(posedge clk); #1;
        pkt_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; byte_in = 8'h00; new_byte = 1'b0; pkt_ready = 1'b0;
        d4_byte = 8'h00; d4_new = 1'b0; d4_ready = 1'b0;
        d1_byte = 8'h00; d1_new = 1'b0; d1_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        n_vec++; if (pkt_valid !== 1'b0) begin n_err++; $display("FAIL reset_valid: got %b want 0", pkt_valid); end
        n_vec++; if (pkt_out !== 528'h0) begin n_err++; $display("FAIL reset_pkt_out: got nonzero want 0"); end
        n_vec++; if ({crc_err, timeout_err, overrun} !== 3'b000) begin n_err++; $display("FAIL reset_flags: got %b want 000", {crc_err, timeout_err, overrun}); end
        n_vec++; if (byte_count !== 7'd0) begin n_err++; $display("FAIL reset_count: got %0d want 0", byte_count); end
        rst = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_good_packet();
        build_packet(1'b0);
        send_range(0, 64);
        n_vec++; if (pkt_valid !== 1'b0) begin n_err++; $display("FAIL good_early_valid: got %b want 0", pkt_valid); end
        n_vec++; if (byte_count !== 7'd65) begin n_err++; $display("FAIL good_count65: got %0d want 65", byte_count); end
        send_range(65, 65);
        n_vec++; if (pkt_valid !== 1'b1) begin n_err++; $display("FAIL good_valid: got %b want 1", pkt_valid); end
        n_vec++; if (pkt_out[527:520] !== 8'h00) begin n_err++; $display("FAIL good_msb: got %h want 00", pkt_out[527:520]); end
        n_vec++; if (pkt_out[23:16] !== 8'h3F) begin n_err++; $display("FAIL good_last_payload: got %h want 3f", pkt_out[23:16]); end
        n_vec++; if (pkt_out !== exp_pkt) begin n_err++; $display("FAIL good_pkt_out: crc bytes got %h want %h", pkt_out[15:0], exp_pkt[15:0]); end
        n_vec++; if (crc_err !== 1'b0) begin n_err++; $display("FAIL good_crc_err: got %b want 0", crc_err); end
        n_vec++; if (byte_count !== 7'd66) begin n_err++; $display("FAIL good_count: got %0d want 66", byte_count); end
        accept_packet();
        n_vec++; if (pkt_valid !== 1'b0) begin n_err++; $display("FAIL good_valid_after_accept: got %b want 0", pkt_valid); end
        n_vec++; if (byte_count !== 7'd0) begin n_err++; $display("FAIL good_count_after_accept: got %0d want 0", byte_count); end
    endtask

    task automatic test_corrupt();
        build_packet(1'b1);
        send_range(0, 65);
        n_vec++; if (pkt_valid !== 1'b1) begin n_err++; $display("FAIL corrupt_valid: got %b want 1", pkt_valid); end
        n_vec++; if (crc_err !== 1'b1) begin n_err++; $display("FAIL corrupt_crc_err: got %b want 1", crc_err); end
        n_vec++; if (pkt_out[447:440] !== 8'h0B) begin n_err++; $display("FAIL corrupt_byte10: got %h want 0b", pkt_out[447:440]); end
        @(posedge clk); #1;
        n_vec++; if (crc_err !== 1'b1) begin n_err++; $display("FAIL corrupt_crc_held: got %b want 1", crc_err); end
        accept_packet();
        n_vec++; if (crc_err !== 1'b0) begin n_err++; $display("FAIL corrupt_crc_after_accept: got %b want 0", crc_err); end
    endtask

    task automatic test_timeout();
        int pulses;
        int at_cycle;
        logic saw_valid;
        build_packet(1'b0);
        send_range(0, 19);
        n_vec++; if (byte_count !== 7'd20) begin n_err++; $display("FAIL timeout_count20: got %0d want 20", byte_count); end
        pulses = 0; at_cycle = -1; saw_valid = 1'b0;
        for (int c = 1; c <= 255; c++) begin
            @(posedge clk); #1;
            if (timeout_err === 1'b1) begin pulses++; at_cycle = c; end
            if (pkt_valid !== 1'b0) saw_valid = 1'b1;
        end
        n_vec++; if (pulses != 1) begin n_err++; $display("FAIL timeout_pulses: got %0d want 1", pulses); end
        n_vec++; if (at_cycle != 255) begin n_err++; $display("FAIL timeout_cycle: got %0d want 255", at_cycle); end
        n_vec++; if (byte_count !== 7'd0) begin n_err++; $display("FAIL timeout_count: got %0d want 0", byte_count); end
        n_vec++; if (saw_valid !== 1'b0) begin n_err++; $display("FAIL timeout_valid: got 1 want 0"); end
        @(posedge clk); #1;
        n_vec++; if (timeout_err !== 1'b0) begin n_err++; $display("FAIL timeout_one_cycle: got %b want 0", timeout_err); end
        send_range(0, 65);
        n_vec++; if (pkt_valid !== 1'b1) begin n_err++; $display("FAIL timeout_next_valid: got %b want 1", pkt_valid); end
        n_vec++; if (pkt_out !== exp_pkt) begin n_err++; $display("FAIL timeout_next_pkt: msb got %h want %h", pkt_out[527:512], exp_pkt[527:512]); end
        n_vec++; if (crc_err !== 1'b0) begin n_err++; $display("FAIL timeout_next_crc: got %b want 0", crc_err); end
    endtask

    task automatic test_overrun();
        byte_in = 8'hAA; new_byte = 1'b1;
        @(posedge clk); #1;
        new_byte = 1'b0;
        n_vec++; if (overrun !== 1'b1) begin n_err++; $display("FAIL overrun_pulse: got %b want 1", overrun); end
        n_vec++; if (pkt_out !== exp_pkt) begin n_err++; $display("FAIL overrun_pkt_kept: lsb got %h want %h", pkt_out[7:0], exp_pkt[7:0]); end
        n_vec++; if ({pkt_valid, byte_count} !== {1'b1, 7'd66}) begin n_err++; $display("FAIL overrun_hold: got %b/%0d want 1/66", pkt_valid, byte_count); end
        @(posedge clk); #1;
        n_vec++; if (overrun !== 1'b0) begin n_err++; $display("FAIL overrun_one_cycle: got %b want 0", overrun); end
        byte_in = 8'h55; new_byte = 1'b1; pkt_ready = 1'b1;
        @(posedge clk); #1;
        new_byte = 1'b0; pkt_ready = 1'b0;
        n_vec++; if (pkt_valid !== 1'b0) begin n_err++; $display("FAIL b2b_valid: got %b want 0", pkt_valid); end
        n_vec++; if (byte_count !== 7'd1) begin n_err++; $display("FAIL b2b_count: got %0d want 1", byte_count); end
        n_vec++; if (pkt_out[7:0] !== 8'h55) begin n_err++; $display("FAIL b2b_lsb: got %h want 55", pkt_out[7:0]); end
        n_vec++; if (overrun !== 1'b0) begin n_err++; $display("FAIL b2b_overrun: got %b want 0", overrun); end
    endtask

    task automatic test_midpacket_reset();
        send_range(1, 29);
        n_vec++; if (byte_count !== 7'd30) begin n_err++; $display("FAIL midrst_count30: got %0d want 30", byte_count); end
        #3 rst = 1'b1;
        #1;
        n_vec++; if (pkt_out !== 528'h0) begin n_err++; $display("FAIL midrst_pkt_out: got nonzero want 0"); end
        n_vec++; if ({pkt_valid, crc_err, timeout_err, overrun} !== 4'b0000) begin n_err++; $display("FAIL midrst_flags: got %b want 0000", {pkt_valid, crc_err, timeout_err, overrun}); end
        n_vec++; if (byte_count !== 7'd0) begin n_err++; $display("FAIL midrst_count: got %0d want 0", byte_count); end
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        build_packet(1'b0);
        send_range(0, 65);
        n_vec++; if (pkt_valid !== 1'b1) begin n_err++; $display("FAIL midrst_next_valid: got %b want 1", pkt_valid); end
        n_vec++; if (pkt_out !== exp_pkt) begin n_err++; $display("FAIL midrst_next_pkt: msb got %h want %h", pkt_out[527:512], exp_pkt[527:512]); end
        n_vec++; if (crc_err !== 1'b0) begin n_err++; $display("FAIL midrst_next_crc: got %b want 0", crc_err); end
        accept_packet();
    endtask

    task automatic test_param_sweep();
        logic [31:0] word;
        word = 32'hDEADBEEF;
        for (int i = 0; i < 4; i++) begin
            d4_byte = word[31-8*i -: 8];
            d4_new  = 1'b1;
            @(posedge clk); #1;
        end
        d4_new = 1'b0;
        n_vec++; if (d4_valid !== 1'b1) begin n_err++; $display("FAIL p4_valid: got %b want 1", d4_valid); end
        n_vec++; if (d4_pkt !== 32'hDEADBEEF) begin n_err++; $display("FAIL p4_pkt: got %h want deadbeef", d4_pkt); end
        n_vec++; if (d4_crc !== 1'b0) begin n_err++; $display("FAIL p4_crc_err: got %b want 0", d4_crc); end
        n_vec++; if (d4_cnt !== 3'd4) begin n_err++; $display("FAIL p4_count: got %0d want 4", d4_cnt); end
        d1_byte = 8'h5A; d1_new = 1'b1;
        @(posedge clk); #1;
        d1_new = 1'b0;
        n_vec++; if (d1_valid !== 1'b1) begin n_err++; $display("FAIL p1_valid: got %b want 1", d1_valid); end
        n_vec++; if (d1_pkt !== 8'h5A) begin n_err++; $display("FAIL p1_pkt: got %h want 5a", d1_pkt); end
        n_vec++; if ({d1_crc, d1_cnt} !== 2'b01) begin n_err++; $display("FAIL p1_crc_count: got %b want 01", {d1_crc, d1_cnt}); end
    endtask

    task automatic test_back_to_back();
        logic [31:0] word;
        word = 32'h11223344;
        d4_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            d4_byte = word[31-8*i -: 8];
            d4_new  = 1'b1;
            @(posedge clk); #1;
            if (i == 0) begin
                n_vec++; if ({d4_valid, d4_cnt} !== {1'b0, 3'd1}) begin n_err++; $display("FAIL p4_b2b_first: got %b/%0d want 0/1", d4_valid, d4_cnt); end
            end
        end
        d4_new = 1'b0;
        n_vec++; if (d4_valid !== 1'b1) begin n_err++; $display("FAIL p4_b2b_valid: got %b want 1", d4_valid); end
        n_vec++; if (d4_pkt !== 32'h11223344) begin n_err++; $display("FAIL p4_b2b_pkt: got %h want 11223344", d4_pkt); end
        @(posedge clk); #1;
        d4_ready = 1'b0;
        n_vec++; if ({d4_valid, d4_cnt} !== {1'b0, 3'd0}) begin n_err++; $display("FAIL p4_b2b_release: got %b/%0d want 0/0", d4_valid, d4_cnt); end
    endtask

    initial begin
        test_reset();
        test_good_packet();
        test_corrupt();
        test_timeout();
        test_overrun();
        test_midpacket_reset();
        test_param_sweep();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
